// File: rtl/serial_mag_comparator_ctrl_if.sv
// Request/result bundle between a requester and the serial magnitude comparator.
// Latency: none, wires only.
// Backpressure: start is only honoured while the controller is idle; no queuing.
interface serial_mag_comparator_ctrl_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic             smaller;
   logic             equal;
   logic             greater;

   // Requester side: drives the request and operands, observes status and result.
   modport master (
      output start, a, b,
      input  busy, done, smaller, equal, greater
   );

   // Controller side: consumes the request, produces status and result.
   modport slave (
      input  start, a, b,
      output busy, done, smaller, equal, greater
   );
endinterface

// File: rtl/serial_mag_comparator_ctrl.sv
// Serial unsigned magnitude comparator: walks a shared 1-bit cell MSB->LSB, stops at first difference.
// Latency: WIDTH-i cycles after acceptance (i = MSB differing bit), WIDTH cycles when equal.
// Backpressure: start is ignored while busy or in the done cycle; no queuing, no abort except reset.

// Shared 1-bit compare cell.
module comparator_1bit (
   input  logic i_a,
   input  logic i_b,
   output logic o_smaller,
   output logic o_equal,
   output logic o_greater
);
   assign o_smaller = ~i_a &  i_b;
   assign o_greater =  i_a & ~i_b;
   assign o_equal   = ~(i_a ^ i_b);
endmodule

module serial_mag_comparator_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   serial_mag_comparator_ctrl_if.slave bus
);
   // Bit index needs at least one bit, even for WIDTH=1.
   localparam int             IW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [IW-1:0]  IDX_MSB = IW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SCAN = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;

   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [IW-1:0]    r_idx;
   logic             r_busy;
   logic             r_done;
   logic             r_smaller;
   logic             r_equal;
   logic             r_greater;

   logic             w_bit_a;
   logic             w_bit_b;
   logic             w_cell_sm;
   logic             w_cell_eq;
   logic             w_cell_gt;
   logic             w_decided;
   logic             w_last;

   logic             w_load;
   logic             w_dec;
   logic             w_set_sm;
   logic             w_set_eq;
   logic             w_set_gt;
   logic             w_busy_nxt;
   logic             w_done_nxt;

   // The cell only ever sees the latched operands, so late changes on a/b are harmless.
   assign w_bit_a = r_a[r_idx];
   assign w_bit_b = r_b[r_idx];

   comparator_1bit u_cell (
      .i_a       (w_bit_a),
      .i_b       (w_bit_b),
      .o_smaller (w_cell_sm),
      .o_equal   (w_cell_eq),
      .o_greater (w_cell_gt)
   );

   assign w_decided = ~w_cell_eq;
   assign w_last    = (r_idx == '0);

   // State register; reset wins over any pending start.
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Next-state: leave SCAN on the first differing bit or after the LSB.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (bus.start) w_state_nxt = S_SCAN;
         S_SCAN:  if (w_decided || w_last) w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Output/control decode: datapath strobes and next values of the registered status.
   always_comb begin
      w_load   = 1'b0;
      w_dec    = 1'b0;
      w_set_sm = 1'b0;
      w_set_eq = 1'b0;
      w_set_gt = 1'b0;
      case (r_state)
         S_IDLE: w_load = bus.start;
         S_SCAN: begin
            w_set_sm = w_cell_sm;
            w_set_gt = w_cell_gt;
            w_set_eq = ~w_decided & w_last;
            w_dec    = ~w_decided & ~w_last;
         end
         default: ;
      endcase
      w_busy_nxt = (w_state_nxt == S_SCAN);
      w_done_nxt = (w_state_nxt == S_DONE);
   end

   // Datapath: operand latch, bit index, sticky result flags and registered status.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_a       <= '0;
         r_b       <= '0;
         r_idx     <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_smaller <= 1'b0;
         r_equal   <= 1'b0;
         r_greater <= 1'b0;
      end else begin
         r_busy <= w_busy_nxt;
         r_done <= w_done_nxt;
         if (w_load) begin
            r_a       <= bus.a;
            r_b       <= bus.b;
            r_idx     <= IDX_MSB;
            r_smaller <= 1'b0;
            r_equal   <= 1'b0;
            r_greater <= 1'b0;
         end
         if (w_dec)    r_idx     <= r_idx - 1'b1;
         if (w_set_sm) r_smaller <= 1'b1;
         if (w_set_eq) r_equal   <= 1'b1;
         if (w_set_gt) r_greater <= 1'b1;
      end
   end

   assign bus.busy    = r_busy;
   assign bus.done    = r_done;
   assign bus.smaller = r_smaller;
   assign bus.equal   = r_equal;
   assign bus.greater = r_greater;
endmodule
